// File: rtl/game_pkg.sv
// Shared types and width helpers for the N x N tic-tac-toe engine.
package game_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    PLAYER = 2'b01,
    CPU    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    NONE  = 2'b00,
    P_WIN = 2'b01,
    C_WIN = 2'b10,
    DRAW  = 2'b11
  } winner_t;

  typedef enum logic [1:0] {
    P_TURN,
    C_TURN,
    CHECK,
    OVER
  } state_t;

  function automatic int idx_w(input int n);
    return $clog2(n * n);
  endfunction

  function automatic int cnt_w(input int n);
    return $clog2(n * n + 1);
  endfunction

  function automatic int rc_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/game_engine_if.sv
// Move handshakes and board/status export between the engine and its clients.
interface game_engine_if #(
  parameter int N = 3
);
  import game_pkg::*;

  localparam int C     = N * N;
  localparam int IDX_W = idx_w(N);
  localparam int CNT_W = cnt_w(N);

  logic             mode;
  logic             new_game;
  logic             move_valid;
  logic [IDX_W-1:0] move_pos;
  logic             move_ready;
  logic             cpu_valid;
  logic [IDX_W-1:0] cpu_pos;
  logic             cpu_ready;
  logic [2*C-1:0]   board;
  logic             turn;
  logic             game_over;
  logic [1:0]       winner;
  logic             illegal;
  logic [CNT_W-1:0] move_count;

  modport master (
    output mode, new_game, move_valid, move_pos, cpu_valid, cpu_pos,
    input  move_ready, cpu_ready, board, turn, game_over, winner, illegal, move_count
  );

  modport slave (
    input  mode, new_game, move_valid, move_pos, cpu_valid, cpu_pos,
    output move_ready, cpu_ready, board, turn, game_over, winner, illegal, move_count
  );

endinterface

// File: rtl/game_engine_win_detect.sv
// Combinational line check: does the mark at (row, col) complete its row,
// column or either diagonal.
module win_detect #(
  parameter int N = 3
) (
  input  logic [2*N*N-1:0]     board,
  input  logic [1:0]           mark,
  input  logic [$clog2(N)-1:0] row,
  input  logic [$clog2(N)-1:0] col,
  output logic                 win
);

  logic [1:0] cells [N][N];
  logic       row_hit;
  logic       col_hit;
  logic       dia_hit;
  logic       anti_hit;

  genvar gi, gj;
  generate
    for (gi = 0; gi < N; gi++) begin : g_row
      for (gj = 0; gj < N; gj++) begin : g_col
        assign cells[gi][gj] = board[2*(gi*N+gj) +: 2];
      end
    end
  endgenerate

  // Diagonals only count when the placed cell actually lies on them.
  always_comb begin
    row_hit  = 1'b1;
    col_hit  = 1'b1;
    dia_hit  = (row == col);
    anti_hit = ((int'(row) + int'(col)) == (N - 1));
    for (int k = 0; k < N; k++) begin
      if (cells[row][k] != mark)     row_hit  = 1'b0;
      if (cells[k][col] != mark)     col_hit  = 1'b0;
      if (cells[k][k] != mark)       dia_hit  = 1'b0;
      if (cells[k][N-1-k] != mark)   anti_hit = 1'b0;
    end
    win = row_hit | col_hit | dia_hit | anti_hit;
  end

endmodule

// File: rtl/game_engine.sv
// Turn controller: arbitrates player/CPU moves, rejects illegal ones and
// resolves wins and draws one cycle after each accepted move.
module game_engine
  import game_pkg::*;
#(
  parameter int N     = 3,
  parameter bit FIRST = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  game_engine_if.slave  bus
);

  localparam int C     = N * N;
  localparam int IDX_W = idx_w(N);
  localparam int CNT_W = cnt_w(N);
  localparam int RC_W  = rc_w(N);

  localparam logic [IDX_W:0]   C_EXT = (IDX_W+1)'(C);
  localparam logic [CNT_W-1:0] C_CNT = CNT_W'(C);
  localparam state_t FIRST_STATE     = FIRST ? C_TURN : P_TURN;

  state_t           state_q, state_d;
  logic [2*C-1:0]   board_q, board_d;
  logic [CNT_W-1:0] count_q, count_d;
  winner_t          winner_q, winner_d;
  logic             illegal_q, illegal_d;
  logic             mover_q, mover_d;
  logic [IDX_W-1:0] last_pos_q, last_pos_d;

  logic             move_rdy;
  logic             cpu_rdy;
  logic             take;
  logic             take_side;
  logic [IDX_W-1:0] take_pos;
  logic [1:0]       take_mark;
  logic [C-1:0]     sel;
  logic [C-1:0]     busy;
  logic             in_range;
  logic             legal;
  logic [1:0]       check_mark;
  logic [RC_W-1:0]  chk_row;
  logic [RC_W-1:0]  chk_col;
  logic             line_win;

  // In PvP mode the second human also drives move_*, so cpu_* is shut out.
  assign move_rdy  = (state_q == P_TURN) || ((state_q == C_TURN) && bus.mode);
  assign cpu_rdy   = (state_q == C_TURN) && !bus.mode;
  assign take      = (move_rdy && bus.move_valid) || (cpu_rdy && bus.cpu_valid);
  assign take_side = (state_q == C_TURN);
  assign take_pos  = cpu_rdy ? bus.cpu_pos : bus.move_pos;
  assign take_mark = take_side ? CPU : PLAYER;

  genvar gi;
  generate
    for (gi = 0; gi < C; gi++) begin : g_cell
      assign sel[gi]  = ({1'b0, take_pos} == (IDX_W+1)'(gi));
      assign busy[gi] = |board_q[2*gi +: 2];
    end
  endgenerate

  assign in_range = ({1'b0, take_pos} < C_EXT);
  assign legal    = in_range && !(|(sel & busy));

  assign check_mark = mover_q ? CPU : PLAYER;

  always_comb begin
    chk_row = RC_W'(int'(last_pos_q) / N);
    chk_col = RC_W'(int'(last_pos_q) % N);
  end

  win_detect #(.N(N)) u_win (
    .board (board_q),
    .mark  (check_mark),
    .row   (chk_row),
    .col   (chk_col),
    .win   (line_win)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= FIRST_STATE;
      board_q    <= '0;
      count_q    <= '0;
      winner_q   <= NONE;
      illegal_q  <= 1'b0;
      mover_q    <= FIRST;
      last_pos_q <= '0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      count_q    <= count_d;
      winner_q   <= winner_d;
      illegal_q  <= illegal_d;
      mover_q    <= mover_d;
      last_pos_q <= last_pos_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    count_d    = count_q;
    winner_d   = winner_q;
    illegal_d  = 1'b0;
    mover_d    = mover_q;
    last_pos_d = last_pos_q;
    unique case (state_q)
      P_TURN, C_TURN: begin
        if (take) begin
          if (legal) begin
            for (int i = 0; i < C; i++) begin
              if (sel[i]) board_d[2*i +: 2] = take_mark;
            end
            count_d    = count_q + CNT_W'(1);
            mover_d    = take_side;
            last_pos_d = take_pos;
            state_d    = CHECK;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      // A line win on the final cell outranks the draw.
      CHECK: begin
        if (line_win) begin
          winner_d = mover_q ? C_WIN : P_WIN;
          state_d  = OVER;
        end else if (count_q == C_CNT) begin
          winner_d = DRAW;
          state_d  = OVER;
        end else begin
          state_d = mover_q ? P_TURN : C_TURN;
        end
      end
      OVER: begin
        if (bus.new_game) begin
          board_d  = '0;
          count_d  = '0;
          winner_d = NONE;
          state_d  = FIRST_STATE;
        end
      end
      default: state_d = FIRST_STATE;
    endcase
  end

  always_comb begin
    unique case (state_q)
      P_TURN:  bus.turn = 1'b0;
      C_TURN:  bus.turn = 1'b1;
      default: bus.turn = mover_q;
    endcase
  end

  assign bus.move_ready = move_rdy;
  assign bus.cpu_ready  = cpu_rdy;
  assign bus.board      = board_q;
  assign bus.game_over  = (state_q == OVER);
  assign bus.winner     = winner_q;
  assign bus.illegal    = illegal_q;
  assign bus.move_count = count_q;

endmodule

// File: doc/game_engine.md
# game_engine

Parametrised N×N tic-tac-toe turn controller.
- Replaces the fixed 3×3 game loop.
- Arbitrates moves from the human position input and the CPU opponent (or a second human).
- Rejects illegal moves and detects full-line wins and draws.
- Exports the board state to the VGA renderer.

## Interface
Parameters:
- N, 3, board dimension (3..8); cell count C = N*N.
- FIRST, 0, side that moves first after reset/new game: 0 = player, 1 = CPU.
- IDX_W, $clog2(N*N), localparam, move index width.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high; clears board, returns to first-turn state.
- mode  in  1  0 = player vs CPU, 1 = player vs player (both sides use move_*); sampled only in turn states.
- new_game  in  1  single-cycle pulse; honoured only in OVER.
- move_valid  in  1  player move request.
- move_pos  in  IDX_W  player cell index, row-major, 0 = top-left.
- move_ready  out  1  engine accepts move_* this cycle.
- cpu_valid  in  1  CPU move request.
- cpu_pos  in  IDX_W  CPU cell index.
- cpu_ready  out  1  engine accepts cpu_* this cycle.
- board  out  2*C  cell i at [2i+1:2i]: 00 empty, 01 player, 10 CPU.
- turn  out  1  side to move: 0 player, 1 CPU/second player.
- game_over  out  1  high in OVER.
- winner  out  2  00 none, 01 player, 10 CPU, 11 draw.
- illegal  out  1  one-cycle pulse on rejected move.
- move_count  out  $clog2(C+1)  accepted legal moves this game.

## Operation
- States: P_TURN, C_TURN, CHECK, OVER. Reset → P_TURN if FIRST=0, else C_TURN.
- P_TURN: move_ready=1. On move_valid, handshake completes.
  - Legal (pos < C and cell empty): write 01 to cell, increment move_count, → CHECK.
  - Illegal: pulse illegal, board unchanged, stay in P_TURN.
- C_TURN:
  - mode=0: cpu_ready=1, cpu_* handled like P_TURN, writes 10.
  - mode=1: cpu_ready=0, move_ready=1, move_* writes 10.
- CHECK: evaluate only the mark just placed; a win needs a full N-cell row, column, main diagonal or anti-diagonal.
  - Win → winner = mover's code, → OVER.
  - Else move_count == C → winner=11, → OVER.
  - Else → other side's turn state.
- OVER: both readies 0, board frozen. new_game clears board, move_count and winner, then enters the FIRST state.
- turn follows the state: 0 in P_TURN, 1 in C_TURN, holds the mover's value in CHECK/OVER.
- Reset values: board=0, winner=00, game_over=0, illegal=0, move_count=0, turn=FIRST, move_ready=!FIRST, cpu_ready=FIRST (mode=0).
- cpu_valid outside C_TURN and move_valid outside its turn are ignored; nothing is queued.

## Timing
- Readies are registered-state decodes: valid is taken in the same cycle it is seen with ready.
- Accept at edge k: board/move_count update at k+1, state CHECK during k+1; winner/game_over/next ready valid at k+2. The minimum move-to-move spacing is 2 cycles.
- illegal is high for exactly the cycle after the rejected handshake. A new attempt may be made in that same cycle.
- Simultaneous move_valid and cpu_valid: only the current turn's port is looked at.
- Win on the final cell: win takes priority over draw.
- reset has priority over every input including new_game. Reset mid-CHECK discards the pending result.
- new_game outside OVER is ignored.

## Structure
- Package game_pkg:
  - cell codes EMPTY/PLAYER/CPU;
  - winner codes NONE/P_WIN/C_WIN/DRAW;
  - state enum;
  - index-width function.
- Sub-module win_detect: combinational, parameter N. Inputs: board, mark (2b), row, col. Output: win. Checks only the lines through (row, col).
- Engine holds the FSM, board register, counter and handshake logic.

## Test plan
- N=3, FIRST=0, mode=0.
  - Player 0,1,2 and CPU 3,4 interleaved → after the last accept +2 cycles: winner=01, game_over=1, board[5:0]=010101.
  - CPU move at index 4 already holding 01 → illegal pulse 1 cycle, board unchanged, cpu_ready stays 1.
  - move_pos=9 → illegal, move_count unchanged.
  - Full-board sequence 0,4,8,2,6,3,5,7,1 with no line → winner=11 at move_count=9.
  - Reset asserted the cycle after the 3rd accept → next cycle board=0, move_count=0, move_ready=1.
- N=4, FIRST=1, mode=1: CPU anti-diagonal 3,6,9,12 via move_* → winner=10. A cpu_valid pulse during the game has no effect. new_game in OVER → empty board, C_TURN.
